branch_predictor: RTL and testbench

//  Parametrised direction predictor for the RISC-V pipeline: a table of saturating counters, optionally

---
 rtl/branch_predictor_if.sv | 37 +++
 rtl/branch_predictor.sv | 118 +++++++++++
 tb/tb_branch_predictor.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Pipeline <-> direction predictor connection: FD lookup, X-stage training,
// enable/clear controls and the statistics readout.
// ENTRIES and STAT_WIDTH must match the predictor instance this connects to.
interface branch_predictor_if #(
    parameter int ENTRIES    = 32,
    parameter int STAT_WIDTH = 32
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic                  bp_enable;
    logic                  guess_valid;
    logic [31:0]           guess_pc;
    logic                  guess_taken;
    logic [IDX_W-1:0]      guess_idx;
    logic                  check_valid;
    logic [IDX_W-1:0]      check_idx;
    logic                  check_taken;
    logic                  check_pred;
    logic                  mispredict;
    logic                  clear_stats;
    logic [STAT_WIDTH-1:0] branch_count;
    logic [STAT_WIDTH-1:0] mispred_count;

    // Pipeline side: issues lookups, returns resolved outcomes.
    modport master (
        output bp_enable, guess_valid, guess_pc,
        output check_valid, check_idx, check_taken, check_pred, clear_stats,
        input  guess_taken, guess_idx, mispredict, branch_count, mispred_count
    );

    // Predictor side.
    modport slave (
        input  bp_enable, guess_valid, guess_pc,
        input  check_valid, check_idx, check_taken, check_pred, clear_stats,
        output guess_taken, guess_idx, mispredict, branch_count, mispred_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Saturating-counter direction predictor, bimodal (GHR_WIDTH=0) or gshare.
// Lookup is combinational from the current table state; training, the
// non-speculative global history and the statistics update on the clock edge.
// The counter table needs a whole-table reset and a zero-latency read, so it
// is built from per-entry registers rather than block RAM.
module branch_predictor #(
    parameter int ENTRIES    = 32,
    parameter int CNT_WIDTH  = 2,
    parameter int GHR_WIDTH  = 0,
    parameter int STAT_WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    branch_predictor_if.slave bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'((1 << (CNT_WIDTH - 1)) - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    logic [CNT_WIDTH-1:0]  table_q [ENTRIES];
    logic [IDX_W-1:0]      pc_idx;
    logic [IDX_W-1:0]      ghr_ext;
    logic [IDX_W-1:0]      lookup_idx;
    logic [CNT_WIDTH-1:0]  train_cur;
    logic [CNT_WIDTH-1:0]  train_next;
    logic                  train_en;
    logic                  mispredict_int;
    logic [STAT_WIDTH-1:0] branch_count_reg;
    logic [STAT_WIDTH-1:0] mispred_count_reg;

    assign train_en       = bp.check_valid & bp.bp_enable;
    assign mispredict_int = train_en & (bp.check_taken != bp.check_pred);
    assign pc_idx         = bp.guess_pc[IDX_W+1:2];

    // Global history: absent for bimodal, otherwise shifted with each resolved branch.
    if (GHR_WIDTH == 0) begin : g_bimodal
        assign ghr_ext = '0;
    end else begin : g_gshare
        logic [GHR_WIDTH-1:0] ghr_reg;
        logic [GHR_WIDTH-1:0] ghr_next;

        if (GHR_WIDTH == 1) begin : g_ghr1
            assign ghr_next = bp.check_taken;
        end else begin : g_ghrn
            assign ghr_next = {ghr_reg[GHR_WIDTH-2:0], bp.check_taken};
        end

        if (GHR_WIDTH == IDX_W) begin : g_full
            assign ghr_ext = ghr_reg;
        end else begin : g_pad
            assign ghr_ext = {{(IDX_W - GHR_WIDTH){1'b0}}, ghr_reg};
        end

        // History shifts only on resolved, enabled branches (non-speculative).
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ghr_reg <= '0;
            end else if (train_en) begin
                ghr_reg <= ghr_next;
            end
        end
    end

    assign lookup_idx = pc_idx ^ ghr_ext;

    // Saturating step for the entry being trained; shared by all entries.
    assign train_cur = table_q[bp.check_idx];
    always_comb begin
        train_next = train_cur;
        if (bp.check_taken) begin
            if (train_cur != CNT_MAX) begin
                train_next = train_cur + 1'b1;
            end
        end else begin
            if (train_cur != '0) begin
                train_next = train_cur - 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
        logic [CNT_WIDTH-1:0] cnt_reg;

        // Each counter resets weakly not-taken and loads the trained value when addressed.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_reg <= CNT_INIT;
            end else if (train_en && (bp.check_idx == IDX_W'(gi))) begin
                cnt_reg <= train_next;
            end
        end

        assign table_q[gi] = cnt_reg;
    end

    // Statistics: clear wins over increment; counts wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count_reg  <= '0;
            mispred_count_reg <= '0;
        end else if (bp.clear_stats) begin
            branch_count_reg  <= '0;
            mispred_count_reg <= '0;
        end else if (train_en) begin
            branch_count_reg <= branch_count_reg + 1'b1;
            if (mispredict_int) begin
                mispred_count_reg <= mispred_count_reg + 1'b1;
            end
        end
    end

    // Lookup reads the pre-update table, so same-cycle training is seen next cycle.
    assign bp.guess_idx     = lookup_idx;
    assign bp.guess_taken   = bp.bp_enable & bp.guess_valid & table_q[lookup_idx][CNT_WIDTH-1];
    assign bp.mispredict    = mispredict_int;
    assign bp.branch_count  = branch_count_reg;
    assign bp.mispred_count = mispred_count_reg;
endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: one bimodal instance (A) and one 2-bit gshare
// instance (B). Expected outputs come from a small reference model, are queued
// when stimulus is driven and compared at the following falling edge.
module tb_branch_predictor;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    branch_predictor_if #(.ENTRIES(32), .STAT_WIDTH(32)) bpa ();
    branch_predictor_if #(.ENTRIES(32), .STAT_WIDTH(32)) bpb ();

    branch_predictor #(.ENTRIES(32), .CNT_WIDTH(2), .GHR_WIDTH(0), .STAT_WIDTH(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .bp(bpa.slave)
    );
    branch_predictor #(.ENTRIES(32), .CNT_WIDTH(2), .GHR_WIDTH(2), .STAT_WIDTH(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .bp(bpb.slave)
    );

    typedef struct {
        string       tag;
        int          dut;
        int          field;   // 0 taken, 1 idx, 2 mispredict, 3 branch_count, 4 mispred_count
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t    sb_q[$];
    int          n_compared   = 0;
    int          n_mismatched = 0;

    // reference model
    int          m_tab[2][32];
    int          m_ghr[2];
    logic [31:0] m_bc[2];
    logic [31:0] m_mc[2];
    bit          m_en[2];
    // pulses driven this cycle
    bit          p_valid[2];
    int          p_idx[2];
    bit          p_taken[2];
    bit          p_pred[2];
    bit          p_clear[2];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    function automatic logic [31:0] observe(input int d, input int f);
        logic [31:0] v;
        v = '0;
        if (d == 0) begin
            case (f)
                0: v = {31'd0, bpa.guess_taken};
                1: v = {27'd0, bpa.guess_idx};
                2: v = {31'd0, bpa.mispredict};
                3: v = bpa.branch_count;
                default: v = bpa.mispred_count;
            endcase
        end else begin
            case (f)
                0: v = {31'd0, bpb.guess_taken};
                1: v = {27'd0, bpb.guess_idx};
                2: v = {31'd0, bpb.mispredict};
                3: v = bpb.branch_count;
                default: v = bpb.mispred_count;
            endcase
        end
        return v;
    endfunction

    function automatic int m_idx(input int d, input logic [31:0] pc);
        int base;
        base = int'(pc[6:2]);
        return (d == 1) ? (base ^ m_ghr[1]) : base;
    endfunction

    task automatic expect_out(input string tag, input int d, input int f, input logic [31:0] exp);
        sb_item_t it;
        it.tag = tag; it.dut = d; it.field = f; it.exp = exp;
        sb_q.push_back(it);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 32; i++) m_tab[d][i] = 1;
            m_ghr[d] = 0;
            m_bc[d]  = '0;
            m_mc[d]  = '0;
        end
    endtask

    task automatic set_en(input int d, input bit v);
        m_en[d] = v;
        if (d == 0) bpa.bp_enable = v; else bpb.bp_enable = v;
    endtask

    task automatic lookup(input int d, input logic [31:0] pc, input string tag);
        int idx;
        idx = m_idx(d, pc);
        if (d == 0) begin bpa.guess_valid = 1'b1; bpa.guess_pc = pc; end
        else        begin bpb.guess_valid = 1'b1; bpb.guess_pc = pc; end
        expect_out({tag, " taken"}, d, 0, {31'd0, (m_en[d] && m_tab[d][idx] >= 2)});
        expect_out({tag, " idx"},   d, 1, 32'(idx));
    endtask

    task automatic resolve(input int d, input int idx, input bit taken, input bit pred, input string tag);
        if (d == 0) begin
            bpa.check_valid = 1'b1; bpa.check_idx = 5'(idx);
            bpa.check_taken = taken; bpa.check_pred = pred;
        end else begin
            bpb.check_valid = 1'b1; bpb.check_idx = 5'(idx);
            bpb.check_taken = taken; bpb.check_pred = pred;
        end
        p_valid[d] = 1'b1; p_idx[d] = idx; p_taken[d] = taken; p_pred[d] = pred;
        expect_out({tag, " mispredict"}, d, 2, {31'd0, (m_en[d] && (taken != pred))});
    endtask

    task automatic clear(input int d);
        if (d == 0) bpa.clear_stats = 1'b1; else bpb.clear_stats = 1'b1;
        p_clear[d] = 1'b1;
    endtask

    task automatic expect_stats(input int d, input string tag);
        expect_out({tag, " branch_count"},  d, 3, m_bc[d]);
        expect_out({tag, " mispred_count"}, d, 4, m_mc[d]);
    endtask

    // Compare queued expectations, then advance one clock and update the model.
    task automatic cycle();
        sb_item_t it;
        @(negedge clk);
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            check_val(it.tag, observe(it.dut, it.field), it.exp);
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst_n) begin
                if (p_clear[d]) begin
                    m_bc[d] = '0;
                    m_mc[d] = '0;
                end else if (p_valid[d] && m_en[d]) begin
                    m_bc[d] = m_bc[d] + 1;
                    if (p_taken[d] != p_pred[d]) m_mc[d] = m_mc[d] + 1;
                end
                if (p_valid[d] && m_en[d]) begin
                    if (p_taken[d]) begin
                        if (m_tab[d][p_idx[d]] < 3) m_tab[d][p_idx[d]]++;
                    end else begin
                        if (m_tab[d][p_idx[d]] > 0) m_tab[d][p_idx[d]]--;
                    end
                    if (d == 1) m_ghr[1] = ((m_ghr[1] << 1) | int'(p_taken[d])) & 3;
                end
            end
            p_valid[d] = 1'b0;
            p_clear[d] = 1'b0;
        end
        #1;
        bpa.guess_valid = 1'b0; bpa.check_valid = 1'b0; bpa.clear_stats = 1'b0;
        bpb.guess_valid = 1'b0; bpb.check_valid = 1'b0; bpb.clear_stats = 1'b0;
    endtask

    // Assert reset, check reset-state outputs while held, then release.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        expect_stats(0, tag);
        lookup(0, 32'h0000_0100, tag);
        cycle();
        lookup(1, 32'h0000_0100, {tag, " B"});
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        bpa.guess_valid = 1'b0; bpa.guess_pc = '0; bpa.check_valid = 1'b0; bpa.check_idx = '0;
        bpa.check_taken = 1'b0; bpa.check_pred = 1'b0; bpa.clear_stats = 1'b0;
        bpb.guess_valid = 1'b0; bpb.guess_pc = '0; bpb.check_valid = 1'b0; bpb.check_idx = '0;
        bpb.check_taken = 1'b0; bpb.check_pred = 1'b0; bpb.clear_stats = 1'b0;
        for (int d = 0; d < 2; d++) begin
            set_en(d, 1'b1);
            p_valid[d] = 1'b0; p_clear[d] = 1'b0; p_idx[d] = 0; p_taken[d] = 1'b0; p_pred[d] = 1'b0;
        end
        model_reset();
        @(posedge clk);
        #1;

        // 1: reset state
        do_reset("t1 rst");
        lookup(0, 32'h0000_002C, "t1 pc2c");   expect_stats(0, "t1"); cycle();
        lookup(0, 32'h0000_FFFC, "t1 pcfffc"); cycle();

        // 2: saturating counter on idx 0 (pc 0x100)
        resolve(0, 0, 1'b1, 1'b0, "t2 T"); cycle();
        lookup(0, 32'h0000_0100, "t2 after T"); cycle();
        for (int i = 0; i < 3; i++) begin resolve(0, 0, 1'b0, 1'b1, "t2 NT"); cycle(); end
        lookup(0, 32'h0000_0100, "t2 after NTx3"); cycle();
        resolve(0, 0, 1'b1, 1'b0, "t2 T1"); cycle();
        lookup(0, 32'h0000_0100, "t2 from floor"); cycle();
        for (int i = 0; i < 4; i++) begin resolve(0, 0, 1'b1, 1'b0, "t2 T"); cycle(); end
        resolve(0, 0, 1'b0, 1'b1, "t2 NT from top"); cycle();
        lookup(0, 32'h0000_0100, "t2 top-1"); cycle();
        resolve(0, 0, 1'b0, 1'b1, "t2 NT"); cycle();
        lookup(0, 32'h0000_0100, "t2 top-2"); cycle();

        // 3: aliasing of 0x100 and 0x180
        lookup(0, 32'h0000_0180, "t3 alias pre"); cycle();
        resolve(0, 0, 1'b1, 1'b0, "t3 T via 180"); cycle();
        lookup(0, 32'h0000_0180, "t3 alias 180"); cycle();
        lookup(0, 32'h0000_0100, "t3 alias 100"); cycle();
        lookup(0, 32'h0000_0184, "t3 neighbour"); cycle();

        // 4: gshare history
        lookup(1, 32'h0000_0100, "t4 ghr0"); cycle();
        resolve(1, 0, 1'b1, 1'b0, "t4 T1"); cycle();
        resolve(1, 0, 1'b1, 1'b0, "t4 T2"); cycle();
        lookup(1, 32'h0000_0100, "t4 ghr11");
        expect_out("t4 gidx const", 1, 1, 32'd3);
        cycle();
        lookup(1, 32'h0000_010C, "t4 pc10c"); cycle();

        // 5: same-cycle lookup and train of idx 5
        lookup(0, 32'h0000_0014, "t5 same");
        resolve(0, 5, 1'b1, 1'b0, "t5 train");
        expect_out("t5 same const", 0, 0, 32'd0);
        cycle();
        lookup(0, 32'h0000_0014, "t5 next");
        expect_out("t5 next const", 0, 0, 32'd1);
        cycle();

        // 6: statistics
        clear(0); cycle();
        expect_stats(0, "t6 cleared"); cycle();
        for (int i = 0; i < 10; i++) begin
            bit tk;
            tk = i[0];
            resolve(0, 8 + (i % 4), tk, (i < 3) ? !tk : tk, $sformatf("t6 res%0d", i));
            cycle();
        end
        expect_stats(0, "t6 10/3");
        expect_out("t6 bc const", 0, 3, 32'd10);
        expect_out("t6 mc const", 0, 4, 32'd3);
        cycle();
        clear(0); resolve(0, 9, 1'b1, 1'b0, "t6 clr+res"); cycle();
        expect_out("t6 clr bc", 0, 3, 32'd0);
        expect_out("t6 clr mc", 0, 4, 32'd0);
        cycle();

        set_en(0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            resolve(0, 5, 1'b0, 1'b1, "t6 dis res");
            lookup(0, 32'h0000_0014, "t6 dis look");
            cycle();
        end
        expect_stats(0, "t6 dis");
        expect_out("t6 dis bc const", 0, 3, 32'd0);
        cycle();
        set_en(0, 1'b1);
        lookup(0, 32'h0000_0014, "t6 reen"); cycle();
        resolve(0, 5, 1'b1, 1'b0, "t6 reen res"); cycle();
        expect_stats(0, "t6 reen"); cycle();

        // mid-run reset
        do_reset("t6 midrst");
        lookup(0, 32'h0000_0014, "t6 post rst 14"); expect_stats(0, "t6 post rst"); cycle();
        lookup(0, 32'h0000_0100, "t6 post rst 100"); cycle();
        lookup(1, 32'h0000_0100, "t6 post rst B"); cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
